// File: rtl/mul_pkg.sv
// Shared types and width helpers for the sequential multiplier family.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_PW    = 2 * DEF_WIDTH;
  localparam int DEF_CW    = $clog2(DEF_WIDTH + 1);

  // Product width for a given operand width.
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  // Bit-counter width able to hold 0..w.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mul_operand_cond.sv
// Operand conditioning: magnitudes plus result sign, shared with the divider.
module mul_operand_cond #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic [WIDTH-1:0] mag_a,
  output logic [WIDTH-1:0] mag_b,
  output logic             neg
);

  // |-2^(WIDTH-1)| wraps to itself, which is the correct unsigned magnitude.
  always_comb begin
    neg   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    mag_a = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
    mag_b = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

endmodule

// File: rtl/seq_mul_hs.sv
// Shift-add multiplier, one multiplier bit per cycle, valid/ready on both sides.
module seq_mul_hs
  import mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int PW = prod_w(WIDTH);
  localparam int CW = cnt_w(WIDTH);

  logic [WIDTH-1:0] mag_a, mag_b;
  logic             neg;

  mul_operand_cond #(.WIDTH(WIDTH)) u_cond (
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .mag_a       (mag_a),
    .mag_b       (mag_b),
    .neg         (neg)
  );

  state_t           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;   // mag_a pre-shifted to the current bit weight
  logic [WIDTH-1:0] mplier_q, mplier_d; // mag_b, LSB is the bit consumed this edge
  logic             neg_q, neg_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    product_q, product_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic [PW-1:0]    acc_sum;

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d    = {{WIDTH{1'b0}}, mag_a};
          mplier_d   = mag_b;
          neg_d      = neg;
          acc_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // -0 == 0 in two's complement, so a zero product never goes negative.
          product_d   = neg_q ? (~acc_sum + 1'b1) : acc_sum;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_mul_hs.sv
// Directed and randomised checks of seq_mul_hs at WIDTH=32 and WIDTH=8.
module tb_seq_mul_hs;

  logic clk, rst;

  logic        in_valid32, in_ready32, sm32, out_valid32, out_ready32, busy32;
  logic [31:0] a32, b32;
  logic [63:0] prod32;

  logic        in_valid8, in_ready8, sm8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;

  int total = 0;
  int bad   = 0;

  seq_mul_hs #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .signed_mode(sm32), .out_valid(out_valid32),
    .out_ready(out_ready32), .product(prod32), .busy(busy32)
  );

  seq_mul_hs #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .signed_mode(sm8), .out_valid(out_valid8),
    .out_ready(out_ready8), .product(prod8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      input logic [15:0] exp, input int stall, input string tag);
    int cyc;
    cyc = 0;
    while (!in_ready8 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    chk({tag, "_rdy"}, 64'(in_ready8), 64'd1);
    a8 = a; b8 = b; sm8 = sm; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    a8 = ~a; b8 = b + 8'd1; sm8 = ~sm;
    cyc = 0;
    while (!out_valid8 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    chk({tag, "_lat"}, 64'(cyc), 64'd8);
    chk({tag, "_prod"}, 64'(prod8), 64'(exp));
    repeat (stall) begin @(posedge clk); #1; end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk({tag, "_hs"}, {62'd0, out_valid8, in_ready8}, 64'd1);
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic sm,
                       input logic [63:0] exp, input int stall, input string tag);
    int cyc;
    cyc = 0;
    while (!in_ready32 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    chk({tag, "_rdy"}, 64'(in_ready32), 64'd1);
    a32 = a; b32 = b; sm32 = sm; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    a32 = ~a; b32 = b + 32'd1; sm32 = ~sm;
    cyc = 0;
    while (!out_valid32 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    chk({tag, "_lat"}, 64'(cyc), 64'd32);
    chk({tag, "_prod"}, prod32, exp);
    repeat (stall) begin @(posedge clk); #1; end
    out_ready32 = 1'b1;
    @(posedge clk); #1;
    out_ready32 = 1'b0;
    chk({tag, "_hs"}, {62'd0, out_valid32, in_ready32}, 64'd1);
  endtask

  initial begin
    int cyc;
    logic [7:0]         ra8, rb8;
    logic [31:0]        ra32, rb32;
    logic signed [15:0] sa8, sb8;
    logic signed [63:0] sa32, sb32;
    logic [15:0]        e8;
    logic [63:0]        e32;
    logic               rsm;

    rst = 1'b1;
    in_valid32 = 0; out_ready32 = 0; a32 = '0; b32 = '0; sm32 = 0;
    in_valid8  = 0; out_ready8  = 0; a8  = '0; b8  = '0; sm8  = 0;
    @(posedge clk); #1;
    chk("rst32_ctl", {61'd0, in_ready32, out_valid32, busy32}, 64'b100);
    chk("rst32_prod", prod32, 64'd0);
    chk("rst8_ctl", {61'd0, in_ready8, out_valid8, busy8}, 64'b100);
    chk("rst8_prod", 64'(prod8), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run32(32'hFFFF_FFF9, 32'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, 0, "s32_m7x6");
    run32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 2, "s32_minxmin");
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0, "u32_maxxmax");
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1, 1, "s32_m1xm1");
    run8(8'h00, 8'hFB, 1'b1, 16'h0000, 0, "s8_0xm5");
    run8(8'h80, 8'h7F, 1'b1, 16'hC080, 0, "s8_minx127");
    run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 0, "u8_maxxmax");

    // Back-pressure: product held, no second accept until after the handoff.
    a8 = 8'd3; b8 = 8'd4; sm8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    cyc = 0;
    while (!out_valid8 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    chk("bp_lat", 64'(cyc), 64'd8);
    a8 = 8'd9; b8 = 8'd9; in_valid8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_ctl", {61'd0, out_valid8, in_ready8, busy8}, 64'b101);
      chk("bp_hold_prod", 64'(prod8), 64'd12);
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk("bp_handoff", {61'd0, out_valid8, in_ready8, busy8}, 64'b010);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    chk("bp_second_acc", {62'd0, in_ready8, busy8}, 64'b01);
    cyc = 0;
    while (!out_valid8 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    chk("bp2_lat", 64'(cyc), 64'd8);
    chk("bp2_prod", 64'(prod8), 64'd81);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;

    // Asynchronous reset partway through RUN.
    a8 = 8'd100; b8 = 8'd3; sm8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_busy", 64'(busy8), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ctl", {61'd0, in_ready8, out_valid8, busy8}, 64'b100);
    chk("mid_rst_prod", 64'(prod8), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run8(8'd5, 8'd5, 1'b0, 16'd25, 0, "rst_next");

    for (int i = 0; i < 300; i++) begin
      ra8 = 8'($urandom); rb8 = 8'($urandom); rsm = 1'($urandom);
      sa8 = $signed(ra8); sb8 = $signed(rb8);
      e8 = rsm ? 16'(sa8 * sb8) : 16'({8'd0, ra8} * {8'd0, rb8});
      run8(ra8, rb8, rsm, e8, int'($urandom_range(0, 3)), "rnd8");
    end
    for (int i = 0; i < 300; i++) begin
      ra32 = $urandom; rb32 = $urandom; rsm = 1'($urandom);
      sa32 = $signed(ra32); sb32 = $signed(rb32);
      e32 = rsm ? 64'(sa32 * sb32) : 64'({32'd0, ra32} * {32'd0, rb32});
      run32(ra32, rb32, rsm, e32, int'($urandom_range(0, 3)), "rnd32");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
